// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: op, state and fault encodings plus default sizes for the program-counter sequencer
package pc_seq_pkg;
  localparam int ADDR_W = 11;
  localparam int DEPTH = 16;
  typedef enum logic [2:0] {NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, CALL = 3'd3, RET = 3'd4} op_t;
  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, OVF = 2'd1, UNF = 2'd2} fault_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: strobes and data between the sequencer and its parent-owned return stack
interface pc_sequencer_if #(parameter int ADDR_W = pc_seq_pkg::ADDR_W) ();
  logic stack_push;
  logic stack_pop;
  logic stack_clr;
  logic [ADDR_W-1:0] stack_wdata;
  logic [ADDR_W-1:0] stack_rdata;
  modport master (output stack_push, stack_pop, stack_clr, stack_wdata, input stack_rdata);
  modport slave (input stack_push, stack_pop, stack_clr, stack_wdata, output stack_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with call/return via an external stack and sticky overflow/underflow fault
module pc_sequencer #(
  parameter int ADDR_W = pc_seq_pkg::ADDR_W,
  parameter int DEPTH = pc_seq_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              cond,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        depth,
  output logic [1:0]        fault,
  pc_sequencer_if.master    stk
);
  import pc_seq_pkg::*;
  localparam logic [4:0] FULL = 5'(DEPTH);
  state_t state;
  logic [ADDR_W-1:0] pc_inc;
  logic run;
  assign pc_inc = pc + ADDR_W'(1);
  assign run = state == RUN && !stall;
  assign stk.stack_push = run && op == CALL && depth != FULL;
  assign stk.stack_pop = run && op == RET && depth != '0;
  assign stk.stack_wdata = pc_inc;
  assign stk.stack_clr = state == INIT;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      pc <= '0;
      depth <= '0;
      fault <= NONE;
    end else if (state == INIT) state <= RUN;
    else if (run)
      case (op_t'(op))
        JUMP: pc <= target;
        BRANCH: pc <= cond ? target : pc_inc;
        CALL:
          if (depth != FULL) begin
            pc <= target;
            depth <= depth + 5'd1;
          end else begin
            fault <= OVF;
            state <= FAULT;
          end
        RET:
          if (depth != '0) begin
            pc <= stk.stack_rdata;
            depth <= depth - 5'd1;
          end else begin
            fault <= UNF;
            state <= FAULT;
          end
        default: pc <= pc_inc;
      endcase
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 11, program address width (matches 11-bit return-stack entries).
REQ-002 Parameter DEPTH, default 16, return-stack capacity in entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold request; when 1, no state change and no stack strobes.
REQ-006 op  input  3  operation code from pc_seq_pkg: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4; codes 5-7 are reserved and behave as NEXT.
REQ-007 target  input  ADDR_W  jump, branch or call destination.
REQ-008 cond  input  1  branch-taken flag, sampled only when op=BRANCH.
REQ-009 pc  output  ADDR_W  current program counter, registered.
REQ-010 stack_push  output  1  push strobe to the return stack.
REQ-011 stack_pop  output  1  pop strobe to the return stack.
REQ-012 stack_wdata  output  ADDR_W  return address to push.
REQ-013 stack_rdata  input  ADDR_W  top-of-stack entry, combinational from the stack.
REQ-014 stack_clr  output  1  synchronous clear strobe to the return stack.
REQ-015 depth  output  5  number of valid return-stack entries, range 0..DEPTH.
REQ-016 fault  output  2  sticky fault code: NONE=0, OVF=1, UNF=2.

Function
REQ-017 The FSM SHALL have three states: INIT, RUN and FAULT.
REQ-018 INIT SHALL last exactly one cycle with stack_clr=1 and pc held, then move to RUN.
REQ-019 stack_clr SHALL be 1 only in INIT.
REQ-020 stack_push, stack_pop and stack_wdata SHALL be combinational from state, op, stall, depth and pc, so the stack samples them on the same edge that updates pc.
REQ-021 In RUN with stall=1, pc, depth and state SHALL hold, and push and pop SHALL be 0.
REQ-022 NEXT: pc <= pc+1 modulo 2^ADDR_W (2047 wraps to 0).
REQ-023 JUMP: pc <= target.
REQ-024 BRANCH: pc <= target when cond=1, otherwise pc+1 with wrap.
REQ-025 CALL with depth<DEPTH: stack_push=1, stack_wdata=pc+1 with wrap, pc <= target, depth <= depth+1.
REQ-026 CALL with depth=DEPTH: no push, pc held, fault <= OVF, state <= FAULT.
REQ-027 RET with depth>0: stack_pop=1, pc <= stack_rdata sampled in that same cycle, depth <= depth-1.
REQ-028 RET with depth=0: no pop, pc held, fault <= UNF, state <= FAULT.
REQ-029 push and pop SHALL never be asserted in the same cycle.
REQ-030 stack_wdata SHALL equal pc+1 in every cycle, whether or not push is asserted.
REQ-031 FAULT SHALL be terminal until reset: pc, depth and fault held, and all stack strobes 0 regardless of op and stall.

Reset
REQ-032 When reset=0, the block SHALL immediately force pc=0, depth=0, fault=NONE and state=INIT.
REQ-033 Reset asserted mid-operation SHALL abandon any in-flight call or return with no partial update.
REQ-034 The first cycle after reset release SHALL be INIT, so stack_clr=1 and push=pop=0.

Structure
REQ-035 pc_seq_pkg SHALL hold the op, state and fault enums and the constants ADDR_W=11 and DEPTH=16.
REQ-036 The block SHALL contain no sub-module.
REQ-037 The return stack SHALL be instantiated by the parent and connected through the stack_* ports.

Verification
REQ-038 Reset release -> one cycle with stack_clr=1 and pc=0, then RUN; NEXT x3 -> pc=3.
REQ-039 pc=0x010, CALL target=0x200 -> push=1, wdata=0x011, pc=0x200, depth=1; then RET with rdata=0x011 -> pop=1, pc=0x011, depth=0.
REQ-040 16 nested CALLs -> depth=16; a 17th CALL -> push=0, fault=OVF, pc frozen; further ops -> no change.
REQ-041 Fresh reset, RET -> pop=0, fault=UNF; reset low then high -> fault=NONE, pc=0.
REQ-042 pc=0x7FF, NEXT -> pc=0x000; BRANCH cond=0 at 0x100 -> 0x101; BRANCH cond=1 target=0x050 -> 0x050.
REQ-043 CALL with stall=1 -> push=0 and pc/depth unchanged; reset asserted during RUN -> pc=0 asynchronously.
